// File: rtl/combine_pkg.sv
// Shared constants and types for the digital clock / stopwatch slice.
package combine_pkg;

  localparam int DIGIT_W      = 4;
  localparam int SEC_MAX      = 59;
  localparam int MIN_MAX      = 59;
  localparam int HR_MAX       = 23;
  localparam int TICK_DIV_DEF = 1;

  localparam int BTN_INC_MIN  = 0;
  localparam int BTN_START    = 0;
  localparam int BTN_INC_HR   = 1;
  localparam int BTN_CLEAR    = 1;

  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd_pair_t;

endpackage

// File: rtl/combine_if.sv
// Board-side bundle: switches and buttons in, four BCD digits and two lamps out.
interface combine_if;
  import combine_pkg::*;

  logic       sw0;
  logic       sw1;
  logic       sw2;
  logic       sw3;
  logic [3:0] btn;
  bcd_t       led1;
  bcd_t       led2;
  bcd_t       led3;
  bcd_t       led4;
  logic       l_red;
  logic       l_blue;

  modport master (
    output sw0, sw1, sw2, sw3, btn,
    input  led1, led2, led3, led4, l_red, l_blue
  );

  modport slave (
    input  sw0, sw1, sw2, sw3, btn,
    output led1, led2, led3, led4, l_red, l_blue
  );

endinterface

// File: rtl/combine_bcd_mod_counter.sv
// Two-digit BCD counter 00..MAX; clear beats increment, carry flags the wrap.
module bcd_mod_counter
  import combine_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_inc,
  input  logic      i_clr,
  output bcd_pair_t o_q,
  output logic      o_carry
);

  localparam bcd_t MAX_T = bcd_t'(MAX / 10);
  localparam bcd_t MAX_U = bcd_t'(MAX % 10);

  bcd_pair_t r_q;
  logic      w_at_max;

  assign w_at_max = (r_q.tens == MAX_T) && (r_q.units == MAX_U);
  assign o_carry  = i_inc & w_at_max;
  assign o_q      = r_q;

  // NOTE: non-blocking so both digits update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc) begin
      if (w_at_max) begin
        r_q <= '0;
      end else if (r_q.units == bcd_t'(9)) begin
        r_q.units <= '0;
        r_q.tens  <= r_q.tens + bcd_t'(1);
      end else begin
        r_q.units <= r_q.units + bcd_t'(1);
      end
    end
  end

endmodule

// File: rtl/combine_top.sv
// Digital clock top: 1 s prescaler, button edge detect, HH:MM:SS clock,
// MM:SS stopwatch and the display mux feeding four BCD digits.
module combine_top
  import combine_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input logic      clk,
  input logic      rst,
  combine_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [3:0]    r_btn_q;
  logic          r_sw_run;
  logic          r_blue;

  logic          w_tick;
  logic [3:0]    w_rise;
  logic          w_clk_run, w_set, w_sw_mode;
  logic          w_set_min, w_set_hr, w_sw_clr, w_sw_tog;
  logic          w_sec_carry, w_min_carry, w_sw_sec_carry;
  logic          w_unused_hr_carry, w_unused_sw_min_carry;
  bcd_pair_t     w_sec, w_min, w_hr, w_sw_sec, w_sw_min;
  bcd_pair_t     w_left, w_right;

  assign w_tick    = (r_presc == PW'(TICK_DIV - 1));
  assign w_rise    = bus.btn & ~r_btn_q;
  assign w_clk_run = w_tick & bus.sw1 & ~bus.sw0;
  assign w_set     = bus.sw0 & bus.sw3;
  assign w_sw_mode = ~bus.sw3;
  assign w_set_min = w_set & w_rise[BTN_INC_MIN];
  assign w_set_hr  = w_set & w_rise[BTN_INC_HR];
  assign w_sw_clr  = w_sw_mode & w_rise[BTN_CLEAR];
  assign w_sw_tog  = w_sw_mode & w_rise[BTN_START];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc  <= '0;
      r_btn_q  <= '0;
      r_sw_run <= 1'b0;
      r_blue   <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      r_btn_q <= bus.btn;
      if (w_sw_clr)      r_sw_run <= 1'b0;
      else if (w_sw_tog) r_sw_run <= ~r_sw_run;
      if (w_clk_run)     r_blue   <= ~r_blue;
    end
  end

  // Set-mode minute presses must not ripple into the hours.
  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .i_inc(w_clk_run), .i_clr(w_set_min),
    .o_q(w_sec), .o_carry(w_sec_carry));

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .i_inc(w_sec_carry | w_set_min), .i_clr(1'b0),
    .o_q(w_min), .o_carry(w_min_carry));

  bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
    .clk(clk), .rst(rst), .i_inc((w_min_carry & w_clk_run) | w_set_hr), .i_clr(1'b0),
    .o_q(w_hr), .o_carry(w_unused_hr_carry));

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sw_sec (
    .clk(clk), .rst(rst), .i_inc(w_tick & r_sw_run), .i_clr(w_sw_clr),
    .o_q(w_sw_sec), .o_carry(w_sw_sec_carry));

  bcd_mod_counter #(.MAX(MIN_MAX)) u_sw_min (
    .clk(clk), .rst(rst), .i_inc(w_sw_sec_carry), .i_clr(w_sw_clr),
    .o_q(w_sw_min), .o_carry(w_unused_sw_min_carry));

  // NOTE: defaults first so every path assigns both pairs and no latch is inferred.
  always_comb begin
    w_left  = w_sw_min;
    w_right = w_sw_sec;
    if (bus.sw3) begin
      if (bus.sw2) begin
        w_left  = w_hr;
        w_right = w_min;
      end else begin
        w_left  = w_min;
        w_right = w_sec;
      end
    end
  end

  assign bus.led1   = w_left.tens;
  assign bus.led2   = w_left.units;
  assign bus.led3   = w_right.tens;
  assign bus.led4   = w_right.units;
  assign bus.l_red  = r_sw_run;
  assign bus.l_blue = r_blue;

endmodule

// File: tb/tb_combine_top.sv
// Self-checking bench for combine_top: time kept as seconds-of-day and the
// stopwatch as elapsed seconds, compared against the BCD display every cycle.
module tb_combine_top;
  import combine_pkg::*;

  logic clk = 1'b0;
  logic rst;

  combine_if bus ();

  combine_top #(.TICK_DIV(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_tod;
  int         m_sw;
  bit         m_run;
  bit         m_blue;
  logic [3:0] m_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {bus.led1, bus.led2, bus.led3, bus.led4};
  endfunction

  function automatic logic [17:0] observed();
    return {bus.led1, bus.led2, bus.led3, bus.led4, bus.l_red, bus.l_blue};
  endfunction

  function automatic logic [17:0] expected();
    int l;
    int r;
    if (bus.sw3) begin
      if (bus.sw2) begin
        l = m_tod / 3600;
        r = (m_tod / 60) % 60;
      end else begin
        l = (m_tod / 60) % 60;
        r = m_tod % 60;
      end
    end else begin
      l = m_sw / 60;
      r = m_sw % 60;
    end
    return {4'(l / 10), 4'(l % 10), 4'(r / 10), 4'(r % 10), m_run, m_blue};
  endfunction

  task automatic model_reset();
    m_tod  = 0;
    m_sw   = 0;
    m_run  = 1'b0;
    m_blue = 1'b0;
    m_prev = '0;
  endtask

  // Every clock is a 1 s tick with TICK_DIV=1.
  task automatic model_edge();
    logic [3:0] rise;
    int hh, mm, ss;
    bit old_run;
    bit cleared;
    rise    = bus.btn & ~m_prev;
    m_prev  = bus.btn;
    old_run = m_run;
    cleared = 1'b0;
    if (bus.sw1 && !bus.sw0) begin
      m_tod  = (m_tod + 1) % 86400;
      m_blue = !m_blue;
    end
    if (bus.sw0 && bus.sw3) begin
      hh = m_tod / 3600;
      mm = (m_tod / 60) % 60;
      ss = m_tod % 60;
      if (rise[0]) begin
        mm = (mm + 1) % 60;
        ss = 0;
      end
      if (rise[1]) hh = (hh + 1) % 24;
      m_tod = hh * 3600 + mm * 60 + ss;
    end
    if (!bus.sw3) begin
      if (rise[1]) begin
        m_sw    = 0;
        m_run   = 1'b0;
        cleared = 1'b1;
      end else if (rise[0]) begin
        m_run = !m_run;
      end
    end
    if (old_run && !cleared) m_sw = (m_sw + 1) % 3600;
  endtask

  task automatic set_sw(input logic s0, input logic s1, input logic s2, input logic s3);
    bus.sw0 = s0;
    bus.sw1 = s1;
    bus.sw2 = s2;
    bus.sw3 = s3;
  endtask

  // Called at a falling edge: drive, take one rising edge, compare at the next falling edge.
  task automatic step(input logic [3:0] b, input string tag);
    bus.btn = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag, 32'(observed()), 32'(expected()));
  endtask

  task automatic pulse(input logic [3:0] b, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(b, tag);
      step(4'b0000, tag);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.btn = '0;
    set_sw(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 32'(observed()), 32'h0);
    rst = 1'b0;
  endtask

  logic [17:0] saved;

  initial begin
    do_reset();

    // Clock counts MM:SS
    set_sw(1'b0, 1'b1, 1'b0, 1'b1);
    step(4'b0000, "count");
    check("first_tick_digits", 32'(digits()), 32'h0001);
    check("first_tick_blue", 32'(bus.l_blue), 32'h1);
    repeat (59) step(4'b0000, "count");
    check("one_minute_digits", 32'(digits()), 32'h0100);
    check("one_minute_blue", 32'(bus.l_blue), 32'h0);

    // Set mode from 00:00:00
    do_reset();
    set_sw(1'b1, 1'b1, 1'b1, 1'b1);
    pulse(4'b0010, 3, "set_hr");
    pulse(4'b0001, 2, "set_min");
    check("set_0302", 32'(digits()), 32'h0302);
    repeat (5) step(4'b0001, "hold_min");
    step(4'b0000, "hold_min");
    check("hold_one_press", 32'(digits()), 32'h0303);
    repeat (4) step(4'b0000, "frozen");
    check("frozen_in_set", 32'(digits()), 32'h0303);

    // Preset 23:59:59 then roll over
    pulse(4'b0010, 20, "set_hr");
    pulse(4'b0001, 56, "set_min");
    check("preset_2359", 32'(digits()), 32'h2359);
    set_sw(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (59) step(4'b0000, "to_235959");
    check("at_5959", 32'(digits()), 32'h5959);
    set_sw(1'b0, 1'b1, 1'b1, 1'b1);
    step(4'b0000, "midnight");
    check("midnight_hhmm", 32'(digits()), 32'h0000);
    set_sw(1'b0, 1'b0, 1'b0, 1'b1);
    step(4'b0000, "midnight_ss");
    check("midnight_mmss", 32'(digits()), 32'h0000);

    // Stopwatch
    set_sw(1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0001, "sw_start");
    check("sw_red_on", 32'(bus.l_red), 32'h1);
    repeat (75) step(4'b0000, "sw_run");
    check("sw_0115", 32'(digits()), 32'h0115);
    pulse(4'b0001, 1, "sw_stop");
    repeat (3) step(4'b0000, "sw_hold");
    check("sw_stopped_red", 32'(bus.l_red), 32'h0);
    pulse(4'b0010, 1, "sw_clear");
    check("sw_cleared", 32'(observed()), 32'h0);

    // Stopwatch wrap at 59:59
    step(4'b0001, "sw_start2");
    repeat (3599) step(4'b0000, "sw_long");
    check("sw_5959", 32'({digits(), bus.l_red}), 32'h0B2B3);
    step(4'b0000, "sw_wrap");
    check("sw_wrap_0000", 32'({digits(), bus.l_red}), 32'h00001);
    repeat (5) step(4'b0000, "sw_after_wrap");
    step(4'b0011, "sw_both");
    check("sw_both_clear", 32'({digits(), bus.l_red}), 32'h00000);
    step(4'b0000, "sw_both");

    // Clock mode, not set: buttons ignored
    set_sw(1'b0, 1'b0, 1'b1, 1'b1);
    step(4'b0000, "clk_idle");
    saved = expected();
    step(4'b0001, "clk_btn_ignored");
    step(4'b0010, "clk_btn_ignored");
    step(4'b1100, "clk_btn_ignored");
    check("clk_btn_no_change", 32'(observed()), 32'(saved));

    // Randomized mix
    for (int i = 0; i < 800; i++) begin
      set_sw(($urandom_range(0, 9) < 3), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1));
      step(($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)), "random");
    end

    // Async reset mid-run
    set_sw(1'b0, 1'b1, 1'b0, 1'b0);
    step(4'b0001, "pre_reset");
    repeat (10) step(4'b0000, "pre_reset");
    #2 rst = 1'b1;
    #1 check("async_reset", 32'(observed()), 32'h0);
    model_reset();
    bus.btn = '0;
    @(negedge clk);
    rst = 1'b0;
    set_sw(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) step(4'b0000, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
